mem_dma: RTL and testbench
==========================

Name: mem_dma

Overview:
- Bus-initiator block on the CPU/MEMORY request interface (memread/memwrite/memaddr/memwdata out, memrdata in).
- Moves word blocks without CPU involvement:
  - copy mode: source range to destination range, e.g. DRAM to the VGA framebuffer window 0xFFF0_0000–0xFFF4_AFFF;
  - fill mode: writes one constant to a destination range.
- Shares the MEMORY port with the CPU through a req/gnt pair owned by the top-level arbiter.

Parameters:
- WIDTH, 32, data and address width.
- LEN_W, 17, width of the word-count input; covers a full 320x240 framebuffer (76800 words).
- BURST, 16, words moved per grant before the bus is released for one cycle.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- start_i  input  1  one-cycle start pulse; ignored while busy_o=1
- mode_i  input  1  0=copy, 1=fill; sampled at start
- src_i  input  WIDTH  source byte address; sampled at start; bits[1:0] forced 0
- dst_i  input  WIDTH  destination byte address; sampled at start; bits[1:0] forced 0
- len_i  input  LEN_W  word count; sampled at start
- fill_i  input  WIDTH  fill word; sampled at start
- abort_i  input  1  level; stop after the word in flight
- bus_req_o  output  1  request for the MEMORY port
- bus_gnt_i  input  1  grant from the arbiter
- memread_o  output  1  read strobe
- memwrite_o  output  1  write strobe
- memaddr_o  output  WIDTH  byte address
- memwdata_o  output  WIDTH  write data
- memrdata_i  input  WIDTH  read data, valid one cycle after memread_o
- busy_o  output  1  transfer active
- done_o  output  1  one-cycle completion pulse
- aborted_o  output  1  sticky: last transfer ended by abort; cleared on next accepted start
- remain_o  output  LEN_W  words not yet written

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Internal address, count and data registers 0.
- Read latency contract: MEMORY registers the address, so memrdata_i is valid in the cycle after memread_o=1. Data is captured only in that cycle.
- States:
  - IDLE: on start_i, latch src, dst, len, fill, mode; remain_o=len; burst counter=0; clear aborted_o. If len=0, go to DONE; otherwise go to REQ. busy_o=1 in every state except IDLE.
  - REQ: bus_req_o=1. When bus_gnt_i=1, go to RD (copy) or WR (fill). Memory strobes are 0 in this state.
  - RD: memread_o=1, memaddr_o=src. Then go to CAP.
  - CAP: data reg <= memrdata_i; strobes 0. Then go to WR.
  - WR: memwrite_o=1, memaddr_o=dst, memwdata_o = data reg (copy) or fill (fill). Updates: dst+=4; src+=4 in copy mode; remain-=1; burst+=1. Next state, in priority order:
    - remain reaches 0 → DONE;
    - abort_i=1 → DONE with aborted_o=1;
    - burst reaches BURST → REL;
    - otherwise → RD (copy) or stay in WR (fill).
  - REL: bus_req_o=0 for exactly one cycle; burst=0. Then go to REQ.
  - DONE: done_o=1 for one cycle; bus_req_o=0. Then go to IDLE.
- bus_req_o is 1 in REQ, RD, CAP and WR.
- Arbiter contract: gnt is withdrawn only while bus_req_o=0. mem_dma does not recheck gnt in RD, CAP or WR.
- Strobes: memread_o and memwrite_o are never high together. Outside RD/WR, memaddr_o and memwdata_o are 0.
- Throughput: copy = 3 cycles/word; fill = 1 cycle/word. Add one REL+REQ gap (at least 2 cycles) every BURST words.
- Address wrap: address arithmetic is modulo 2^WIDTH with no error (0xFFFF_FFFC + 4 = 0).
- Simultaneous events:
  - start_i while busy: ignored.
  - abort_i and the final word together: normal completion, aborted_o=0.
  - abort_i in REQ: the transfer waits for grant, completes one word, then stops.
- Reset mid-transfer: all strobes drop immediately (async). Words already written are not rolled back.

Test Plan:
- Copy: src=0x1000, dst=0xFFF0_0000, len=3; DRAM holds 0xA, 0xB, 0xC; gnt tied 1 → 3 writes of 0xA/0xB/0xC to 0xFFF0_0000/04/08, done_o pulse on cycle 11 after start, remain_o=0.
- Fill: dst=0x1400, len=40, fill=0x0F0, BURST=16, gnt=1 → writes to 0x1400–0x149C; bus_req_o low for one cycle after the 16th and after the 32nd write; 40 writes total.
- Grant stall: len=2 copy, gnt held 0 for 5 cycles → bus_req_o=1, no strobes until gnt=1, then normal sequence.
- len=0 → done_o one cycle after start, no strobes, bus_req_o stays 0.
- Abort: fill len=100, abort_i raised during word 5 → exactly 5 writes, aborted_o=1, remain_o=95; next start clears aborted_o.
- Async reset during CAP → all outputs 0 in the same cycle; a new start_i=1 with len=1 after reset release completes normally.

Source files
------------

// File: rtl/mem_dma.sv
// Block-move bus initiator: copies a word range or fills it with a constant,
// sharing the MEMORY port with the CPU through a req/gnt handshake.
module mem_dma #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 17,
    parameter int BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] src_i,
    input  logic [WIDTH-1:0] dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [WIDTH-1:0] fill_i,
    input  logic             abort_i,
    output logic             bus_req_o,
    input  logic             bus_gnt_i,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic [WIDTH-1:0] memaddr_o,
    output logic [WIDTH-1:0] memwdata_o,
    input  logic [WIDTH-1:0] memrdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [LEN_W-1:0] remain_o
);

    localparam int BW = $clog2(BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_CAP,
        S_WR,
        S_REL,
        S_DONE
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] src_q, dst_q, data_q, fill_q;
    logic             mode_q;
    logic [LEN_W-1:0] remain_q;
    logic [BW-1:0]    burst_q;
    logic             aborted_q;
    logic             last_word, burst_last;

    assign last_word  = (remain_q == LEN_W'(1));
    assign burst_last = (burst_q == BW'(BURST - 1));
    assign aborted_o  = aborted_q;
    assign remain_o   = remain_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d    = state;
        bus_req_o  = 1'b0;
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        memaddr_o  = '0;
        memwdata_o = '0;
        busy_o     = (state != S_IDLE);
        done_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_d = (len_i == '0) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                bus_req_o = 1'b1;
                if (bus_gnt_i) state_d = mode_q ? S_WR : S_RD;
            end
            S_RD: begin
                bus_req_o = 1'b1;
                memread_o = 1'b1;
                memaddr_o = src_q;
                state_d   = S_CAP;
            end
            S_CAP: begin
                bus_req_o = 1'b1;
                state_d   = S_WR;
            end
            S_WR: begin
                bus_req_o  = 1'b1;
                memwrite_o = 1'b1;
                memaddr_o  = dst_q;
                memwdata_o = mode_q ? fill_q : data_q;
                // Final word outranks abort so a racing abort still completes cleanly.
                if (last_word)       state_d = S_DONE;
                else if (abort_i)    state_d = S_DONE;
                else if (burst_last) state_d = S_REL;
                else                 state_d = mode_q ? S_WR : S_RD;
            end
            S_REL: begin
                state_d = S_REQ;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            data_q    <= '0;
            fill_q    <= '0;
            mode_q    <= 1'b0;
            remain_q  <= '0;
            burst_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        src_q     <= {src_i[WIDTH-1:2], 2'b00};
                        dst_q     <= {dst_i[WIDTH-1:2], 2'b00};
                        fill_q    <= fill_i;
                        mode_q    <= mode_i;
                        remain_q  <= len_i;
                        burst_q   <= '0;
                        aborted_q <= 1'b0;
                    end
                end
                S_CAP: data_q <= memrdata_i;
                S_WR: begin
                    dst_q    <= dst_q + WIDTH'(4);
                    if (!mode_q) src_q <= src_q + WIDTH'(4);
                    remain_q <= remain_q - LEN_W'(1);
                    burst_q  <= burst_q + BW'(1);
                    if (!last_word && abort_i) aborted_q <= 1'b1;
                end
                S_REL: burst_q <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed self-checking bench for mem_dma with a one-cycle-latency memory model.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, mode_i, abort_i, bus_gnt_i;
    logic [31:0] src_i, dst_i, fill_i, memrdata_i;
    logic [16:0] len_i;
    logic        bus_req_o, memread_o, memwrite_o, busy_o, done_o, aborted_o;
    logic [31:0] memaddr_o, memwdata_o;
    logic [16:0] remain_o;

    int total = 0;
    int bad   = 0;

    mem_dma #(.WIDTH(32), .LEN_W(17), .BURST(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .fill_i(fill_i),
        .abort_i(abort_i), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .memaddr_o(memaddr_o),
        .memwdata_o(memwdata_o), .memrdata_i(memrdata_i), .busy_o(busy_o),
        .done_o(done_o), .aborted_o(aborted_o), .remain_o(remain_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dram(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hA;
            32'h0000_1004: return 32'hB;
            32'h0000_1008: return 32'hC;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Registered read port: data appears only in the cycle after the strobe.
    always @(posedge clk) memrdata_i <= memread_o ? dram(memaddr_o) : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          gap_at[$];
    int          st_cyc = 0, done_cyc = 0, rd_n = 0, req_n = 0, bad_n = 0;

    always @(negedge clk) begin
        if (rst && start_i && !busy_o) st_cyc = cyc;
        if (done_o) done_cyc = cyc;
        if (memwrite_o) begin
            wr_addr.push_back(memaddr_o);
            wr_data.push_back(memwdata_o);
        end
        if (memread_o) rd_n++;
        if (bus_req_o) req_n++;
        if (busy_o && !bus_req_o && !done_o) gap_at.push_back(wr_addr.size());
        if ((memread_o && memwrite_o) ||
            (!memread_o && !memwrite_o && (memaddr_o != 0 || memwdata_o != 0)) ||
            (memread_o && memwdata_o != 0))
            bad_n++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [16:0] l, input logic [31:0] f);
        @(posedge clk);
        #1;
        mode_i = m; src_i = s; dst_i = d; len_i = l; fill_i = f; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
        end
        chk(tag, ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int seen;
        seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(negedge clk);
            if (memwrite_o) seen++;
        end
        chk("abort_wait_writes", seen, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b, g, r0, q0, errs, sv;
        rst = 1'b0; start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0; bus_gnt_i = 1'b1;
        src_i = '0; dst_i = '0; len_i = '0; fill_i = '0;
        #12;
        chk("reset_outputs", {busy_o, done_o, aborted_o, bus_req_o, memread_o, memwrite_o,
                              memaddr_o, memwdata_o, remain_o}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Copy three words into the framebuffer window
        b = wr_addr.size(); r0 = rd_n;
        start_op(1'b0, 32'h1000, 32'hFFF0_0000, 17'd3, 32'h0);
        wait_done("copy_done", 50);
        chk("copy_nwr", wr_addr.size() - b, 3);
        chk("copy_nrd", rd_n - r0, 3);
        chk("copy_a0", wr_addr[b],   32'hFFF0_0000);
        chk("copy_d0", wr_data[b],   32'hA);
        chk("copy_a1", wr_addr[b+1], 32'hFFF0_0004);
        chk("copy_d1", wr_data[b+1], 32'hB);
        chk("copy_a2", wr_addr[b+2], 32'hFFF0_0008);
        chk("copy_d2", wr_data[b+2], 32'hC);
        chk("copy_latency", done_cyc - st_cyc, 11);
        chk("copy_remain", remain_o, 0);
        chk("copy_aborted", aborted_o, 0);

        // Fill 40 words with a start pulse while busy that must be ignored
        b = wr_addr.size(); g = gap_at.size();
        start_op(1'b1, 32'h0, 32'h1400, 17'd40, 32'h0F0);
        repeat (3) @(posedge clk);
        start_op(1'b0, 32'h1000, 32'h5000, 17'd1, 32'h0);
        wait_done("fill_done", 200);
        chk("fill_nwr", wr_addr.size() - b, 40);
        errs = 0;
        for (int i = 0; i < 40 && b + i < wr_addr.size(); i++)
            if (wr_addr[b+i] !== 32'h1400 + 32'(4*i) || wr_data[b+i] !== 32'h0F0) errs++;
        chk("fill_words", errs, 0);
        chk("fill_ngaps", gap_at.size() - g, 2);
        chk("fill_gap0", gap_at[g] - b, 16);
        chk("fill_gap1", gap_at[g+1] - b, 32);
        chk("fill_latency", done_cyc - st_cyc, 46);

        // Grant stall
        bus_gnt_i = 1'b0;
        b = wr_addr.size();
        start_op(1'b0, 32'h1004, 32'h2000, 17'd2, 32'h0);
        sv = 0;
        repeat (5) begin
            @(negedge clk);
            if (!(bus_req_o && !memread_o && !memwrite_o)) sv++;
        end
        chk("stall_hold", sv, 0);
        bus_gnt_i = 1'b1;
        wait_done("stall_done", 50);
        chk("stall_nwr", wr_addr.size() - b, 2);
        chk("stall_a0", wr_addr[b],   32'h2000);
        chk("stall_d0", wr_data[b],   32'hB);
        chk("stall_a1", wr_addr[b+1], 32'h2004);
        chk("stall_d1", wr_data[b+1], 32'hC);

        // Zero length
        b = wr_addr.size(); r0 = rd_n; q0 = req_n;
        start_op(1'b0, 32'h1000, 32'h6000, 17'd0, 32'h0);
        wait_done("len0_done", 10);
        chk("len0_latency", done_cyc - st_cyc, 1);
        chk("len0_nwr", wr_addr.size() - b, 0);
        chk("len0_nrd", rd_n - r0, 0);
        chk("len0_req", req_n - q0, 0);

        // Abort during word 5
        b = wr_addr.size();
        start_op(1'b1, 32'h0, 32'h3000, 17'd100, 32'h55);
        wait_writes(5, 50);
        abort_i = 1'b1;
        wait_done("abort_done", 20);
        abort_i = 1'b0;
        chk("abort_nwr", wr_addr.size() - b, 5);
        chk("abort_flag", aborted_o, 1);
        chk("abort_remain", remain_o, 95);
        b = wr_addr.size();
        start_op(1'b0, 32'h1000, 32'h4000, 17'd1, 32'h0);
        chk("abort_cleared", aborted_o, 0);
        wait_done("after_abort_done", 20);
        chk("after_abort_d", wr_data[b], 32'hA);

        // Abort raised with the final word
        b = wr_addr.size();
        start_op(1'b1, 32'h0, 32'h3100, 17'd3, 32'h77);
        wait_writes(3, 20);
        abort_i = 1'b1;
        wait_done("abort_last_done", 20);
        abort_i = 1'b0;
        chk("abort_last_nwr", wr_addr.size() - b, 3);
        chk("abort_last_flag", aborted_o, 0);
        chk("abort_last_remain", remain_o, 0);

        // Abort held while waiting for grant
        bus_gnt_i = 1'b0; abort_i = 1'b1;
        b = wr_addr.size();
        start_op(1'b1, 32'h0, 32'h3200, 17'd10, 32'h99);
        repeat (3) @(negedge clk);
        bus_gnt_i = 1'b1;
        wait_done("abort_req_done", 20);
        abort_i = 1'b0;
        chk("abort_req_nwr", wr_addr.size() - b, 1);
        chk("abort_req_flag", aborted_o, 1);
        chk("abort_req_remain", remain_o, 9);

        // Address wrap with unaligned destination
        b = wr_addr.size();
        start_op(1'b1, 32'h0, 32'hFFFF_FFFA, 17'd3, 32'h1234);
        wait_done("wrap_done", 20);
        chk("wrap_a0", wr_addr[b],   32'hFFFF_FFF8);
        chk("wrap_a1", wr_addr[b+1], 32'hFFFF_FFFC);
        chk("wrap_a2", wr_addr[b+2], 32'h0000_0000);
        chk("wrap_d2", wr_data[b+2], 32'h1234);

        // Async reset while in CAP
        start_op(1'b0, 32'h1000, 32'h7000, 17'd2, 32'h0);
        sv = 0;
        for (int i = 0; i < 20 && sv == 0; i++) begin
            @(negedge clk);
            if (memread_o) sv = 1;
        end
        chk("rstcap_saw_read", sv, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rstcap_outputs", {busy_o, done_o, aborted_o, bus_req_o, memread_o, memwrite_o,
                               memaddr_o, memwdata_o, remain_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        b = wr_addr.size();
        start_op(1'b0, 32'h1008, 32'h7100, 17'd1, 32'h0);
        wait_done("rstcap_done", 20);
        chk("rstcap_nwr", wr_addr.size() - b, 1);
        chk("rstcap_a", wr_addr[b], 32'h7100);
        chk("rstcap_d", wr_data[b], 32'hC);

        chk("bus_protocol", bad_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
